fetch_queue: RTL and testbench

- Parametrised FIFO between the fetch stage and the decode stage of the pipelined CPU.
- Replaces the single-entry IF/ID pipeline register with a DEPTH-entry buffer, so fetch keeps running while decode is stalled.
- Uses the valid/allow_in handshake of the pipeline.
- Adds a synchronous flush for branch cancel, an optional empty-queue bypass, and occupancy status.

---
 rtl/fetch_queue.sv | 88 ++++++++
 tb/tb_fetch_queue.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch-to-decode payload FIFO: DEPTH-entry circular buffer with valid/allow_in
// handshake, synchronous branch-cancel flush and optional empty-queue bypass.
module fetch_queue #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter bit BYPASS = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_allow,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_allow,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop, bypass_xfer;

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);

  // Gating with reset keeps both handshakes idle while reset is held, bypass included.
  assign in_allow = !reset && (!full || flush);

  always_comb begin
    out_valid = 1'b0;
    out_data  = mem_q[rd_ptr_q];
    if (BYPASS && empty) out_data = in_data;
    if (!reset && !flush) begin
      if (!empty)      out_valid = 1'b1;
      else if (BYPASS) out_valid = in_valid;
    end
  end

  assign push        = in_valid && in_allow && !flush;
  assign pop         = out_valid && out_allow;
  // A pop while empty can only be a bypass; such a transfer leaves storage untouched.
  assign bypass_xfer = empty && push && pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (!bypass_xfer) begin
      if (push) begin
        mem_d[wr_ptr_q] = in_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is deliberately not reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a BYPASS=0 and a BYPASS=1 instance share stimulus,
// each tracked by its own queue-level reference model.
module tb_fetch_queue;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset, flush, in_valid, out_allow;
  logic [DW-1:0] in_data;

  logic ia0, ov0, fu0, em0, ia1, ov1, fu1, em1;
  logic [DW-1:0] od0, od1;
  logic [CW-1:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  always #5 clk = ~clk;

  fetch_queue #(.DATA_W(DW), .DEPTH(DEPTH), .BYPASS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_allow(ia0), .out_valid(ov0), .out_data(od0), .out_allow(out_allow),
    .count(cnt0), .full(fu0), .empty(em0));

  fetch_queue #(.DATA_W(DW), .DEPTH(DEPTH), .BYPASS(1'b1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_allow(ia1), .out_valid(ov1), .out_data(od1), .out_allow(out_allow),
    .count(cnt1), .full(fu1), .empty(em1));

  task automatic cmp(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Reference model: each queue holds exactly the payloads accepted but not yet delivered.
  task automatic upd(input int k);
    logic [DW-1:0] t[$];
    bit eov, psh, pp;
    if (k == 1) t = q1; else t = q0;
    if (reset || flush) t.delete();
    else begin
      eov = (t.size() > 0) || (k == 1 && in_valid);
      pp  = eov && out_allow;
      psh = in_valid && (t.size() < DEPTH);
      if (!(t.size() == 0 && psh && pp)) begin
        if (pp)  void'(t.pop_front());
        if (psh) t.push_back(in_data);
      end
    end
    if (k == 1) q1 = t; else q0 = t;
  endtask

  task automatic mon(input int k, input logic ia, input logic ov, input logic [DW-1:0] od,
                     input logic [CW-1:0] cnt, input logic fu, input logic em);
    int sz;
    logic [DW-1:0] hd;
    logic eov, eia;
    if (reset) begin q0.delete(); q1.delete(); end
    sz = (k == 1) ? q1.size() : q0.size();
    hd = in_data;
    if (sz > 0) hd = (k == 1) ? q1[0] : q0[0];
    eov = !reset && !flush && (sz > 0 || (k == 1 && in_valid));
    eia = !reset && (sz < DEPTH || flush);
    cmp("in_allow", k, ia, eia);
    cmp("out_valid", k, ov, eov);
    if (eov) cmp("out_data", k, od, hd);
    cmp("count", k, cnt, sz);
    cmp("full", k, fu, sz == DEPTH);
    cmp("empty", k, em, sz == 0);
  endtask

  always @(posedge clk) begin
    upd(0);
    upd(1);
  end

  always @(negedge clk) begin
    mon(0, ia0, ov0, od0, cnt0, fu0, em0);
    mon(1, ia1, ov1, od1, cnt1, fu1, em1);
  end

  // Apply one cycle of inputs just after the edge; returns mid-cycle for directed checks.
  task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic oa, input logic fl);
    @(posedge clk); #1;
    in_valid = iv; in_data = d; out_allow = oa; flush = fl;
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sent, guard;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'h5A; out_allow = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'h5A, 1'b1, 1'b0);
      cmp("rst_in_allow", 0, ia0, 0);
      cmp("rst_out_valid", 1, ov1, 0);
      cmp("rst_count", 0, cnt0, 0);
    end
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    #2;
    cmp("post_rst_in_allow", 0, ia0, 1);
    cmp("post_rst_empty", 0, em0, 1);

    // fill then drain
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    cyc(1'b1, 8'h44, 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b0, 1'b0);
    cmp("fill_full", 0, fu0, 1);
    cmp("fill_count", 0, cnt0, 4);
    cmp("fill_in_allow", 0, ia0, 0);
    cmp("fill_head", 0, od0, 8'h11);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cmp("drain_empty", 0, em0, 1);

    // full with simultaneous pop
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hA4, 1'b1, 1'b0);
    cmp("fullpop_in_allow", 0, ia0, 0);
    cyc(1'b1, 8'hA4, 1'b0, 1'b0);
    cmp("fullpop_count", 0, cnt0, 3);
    cmp("fullpop_allow_next", 0, ia0, 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cmp("fullpop_refill", 0, cnt0, 4);

    // flush with push and pop in the same cycle
    cyc(1'b1, 8'hBB, 1'b1, 1'b1);
    cmp("flush_count_before", 0, cnt0, 3);
    cmp("flush_out_valid", 0, ov0, 0);
    cmp("flush_out_valid", 1, ov1, 0);
    cmp("flush_in_allow", 0, ia0, 1);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    cmp("flush_count_after", 0, cnt0, 0);
    cmp("flush_empty_after", 0, em0, 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cmp("flush_first_valid", 0, ov0, 1);
    cmp("flush_first_data", 0, od0, 8'hAA);

    // bypass behaviour
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    cmp("byp_valid", 1, ov1, 1);
    cmp("byp_data", 1, od1, 8'h77);
    cmp("nobyp_valid", 0, ov0, 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cmp("byp_count", 1, cnt1, 0);
    cmp("nobyp_count", 0, cnt0, 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    cmp("byp_stall_data", 1, od1, 8'h77);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cmp("byp_stall_count", 1, cnt1, 1);
    cmp("byp_stall_hold", 1, od1, 8'h77);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cmp("byp_stall_hold2", 1, od1, 8'h77);
    cmp("byp_stall_valid", 1, ov1, 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // ordered stream 0..9 with random downstream stalls
    sent = 0; guard = 0;
    while (sent < 10 && guard < 300) begin
      cyc(1'b1, 8'(sent), 1'($urandom_range(1)), 1'b0);
      if (ia0) sent++;
      guard++;
    end
    cmp("stream_sent", 0, sent, 10);
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // random traffic with occasional flush and one asynchronous reset pulse
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(1)), 8'($urandom), 1'($urandom_range(3) != 0),
          1'($urandom_range(15) == 0));
      if (i == 200) begin
        #1 reset = 1'b1;
        #2;
        cmp("async_rst_count", 0, cnt0, 0);
        cmp("async_rst_empty", 1, em1, 1);
        cmp("async_rst_in_allow", 0, ia0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
      end
    end

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
